des_dec_keysched: RTL
=====================

Name: des_dec_keysched

Overview:
- Sequential DES round-key generator. It is the decryption-direction counterpart of the PC-1 key-init permutation.
- Accepts one 64-bit key, applies PC-1, then emits the 16 PC-2 round subkeys one per handshake beat.
- In decrypt mode the order is K16 down to K1, produced by right rotations. In encrypt mode the order is K1 up to K16, produced by left rotations.
- Sits between the key register and the Feistel round datapath.

Parameters:
- NROUNDS, 16, number of subkeys emitted per key. Fixed by DES; any other value is unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- key_in  input  [1:64]  DES key; bit 1 = MSB, DES standard numbering. Parity bits 8,16,...,64 are ignored.
- decrypt  input  1  sampled only at key acceptance. 1 = emit K16..K1; 0 = emit K1..K16.
- key_valid  input  1  key_in/decrypt valid
- key_ready  output  1  block can accept a key
- sk_out  output  [1:48]  current subkey; bit 1 = MSB
- sk_idx  output  4  DES round number i of sk_out, encoded i-1 (0..15)
- sk_valid  output  1  sk_out valid
- sk_ready  input  1  consumer accepts sk_out
- sk_last  output  1  high with the 16th beat of a key

Behaviour:
- Registers: C[28], D[28], cnt[4], dir, state. sk_out is PC-2 of {C,D}, driven from registers only (no combinational path from inputs).
- Reset values (rst high, synchronous, any state): state=IDLE, C=D=0, cnt=0, dir=0. Outputs: key_ready=1 (on the cycle after reset), sk_valid=0, sk_last=0, sk_idx=0, sk_out=PC-2(0)=0.
- Shift schedule S[i], i=1..16: 1 for i in {1,2,9,16}, 2 otherwise. Total 28, so C16=C0 and D16=D0.
- States:
  - IDLE:
    - key_ready=1, sk_valid=0.
    - On key_valid & key_ready: {C,D} = PC-1(key_in), with C = PC-1 bits 1..28 and D = bits 29..56. dir=decrypt, cnt=0, go to EMIT.
    - Encrypt: C,D additionally rotated left by S[1]=1 in the same cycle, giving C1/D1.
    - Decrypt: no rotation, giving C16=C0 and D16=D0.
  - EMIT:
    - key_ready=0, sk_valid=1.
    - sk_idx = cnt when dir=0; 15-cnt when dir=1.
    - sk_last = (cnt==15).
    - On sk_valid & sk_ready with cnt<15: cnt++ and rotate for the next round.
      - Encrypt: rotate C and D left by S[cnt+2].
      - Decrypt: rotate C and D right by S[16-cnt]. Sequence of right shifts after the first beat: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
    - On accept with cnt==15: go to IDLE.
- Latency: key accepted in cycle T gives sk_valid=1 in cycle T+1. At full throughput, 16 consecutive beats in cycles T+1..T+16. key_ready returns in T+17, so there is one bubble between keys.
- Backpressure: while sk_valid & !sk_ready, sk_out, sk_idx, sk_last, C, D and cnt hold stable.
- key_valid during EMIT: ignored, key not consumed. key_in and decrypt changes during EMIT have no effect.
- Reset mid-stream: the key is abandoned and state returns to IDLE next cycle. No sk_last is issued for the aborted key.
- Rotations are modulo 28 within C and within D independently; no bits cross between C and D.

Test Plan:
- Decrypt, key_in=64'h133457799BBCDFF1, decrypt=1, sk_ready=1 -> sk_valid in cycle T+1.
  - Beat 1: sk_out=48'hCB3D8B0E17F5, sk_idx=15.
  - Beat 2: 48'hBF918D3D3F0A, sk_idx=14.
  - Beat 16: 48'h1B02EFFC7072, sk_idx=0, sk_last=1.
  - key_ready=1 in T+17.
- Encrypt, same key, decrypt=0 -> beat 1 = 48'h1B02EFFC7072 (idx 0), beat 2 = 48'h79AED9DBC9E5 (idx 1), beat 16 = 48'hCB3D8B0E17F5 (idx 15, sk_last=1). The full sequence equals the reverse of the decrypt run.
- Parity-bit insensitivity: key_in=64'h123457799BBCDFF1 (bit 8 flipped), decrypt=1 -> all 16 subkeys identical to the first scenario.
- Backpressure: sk_ready low for 5 cycles at beat 3, plus random toggling thereafter -> outputs held while stalled. Exactly 16 accepted beats, in the same order and with the same values as the first scenario. key_valid pulses mid-stream are ignored.
- Reset mid-operation: assert rst at beat 7 for one cycle -> next cycle sk_valid=0 and key_ready=1. A new key (encrypt) then yields a clean K1..K16 sequence.
- Back-to-back keys: the second key is presented continuously -> it is accepted in the cycle after the first key's sk_last beat. Second key's beat 1 appears exactly 2 cycles after the first key's last beat.

Source files
------------

// File: rtl/des_dec_keysched.sv
// rtl/des_dec_keysched.sv - sequential DES round-key generator (encrypt or decrypt order)
//
// Takes one 64-bit DES key and applies PC-1. It then emits the 16 PC-2 round
// subkeys one per sk_valid/sk_ready beat.
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   key_in, decrypt   : key (bit 1 = MSB) and direction, qualified by key_valid
//   key_valid/ready   : key handshake; ready only while idle
//   sk_out            : current 48-bit subkey (bit 1 = MSB), PC-2 of {C,D}
//   sk_idx            : DES round number of sk_out minus one
//   sk_valid/ready    : subkey handshake
//   sk_last           : marks the 16th subkey of a key
// Encrypt order is K1..K16, produced by left rotations.
// Decrypt order is K16..K1, produced by right rotations starting from C0/D0.
// C0/D0 serve as the start point because C16 = C0 and D16 = D0.

module des_dec_keysched #(
  parameter int NROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:64] key_in,
  input  logic        decrypt,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [1:48] sk_out,
  output logic [3:0]  sk_idx,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic        sk_last
);

  localparam logic [3:0] LAST = 4'(NROUNDS - 1);

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state;
  logic [1:28] c;
  logic [1:28] d;
  logic [3:0]  cnt;
  logic        dir;
  logic [1:56] pc1_key;

  function automatic logic [1:56] pc1(input logic [1:64] k);
    logic [1:56] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[i+1] = k[PC1_TAB[i]];
    return r;
  endfunction

  function automatic logic [1:48] pc2(input logic [1:56] cd);
    logic [1:48] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[i+1] = cd[PC2_TAB[i]];
    return r;
  endfunction

  // True when round i uses a 2-bit shift; rounds 1, 2, 9 and 16 shift by 1.
  function automatic logic two_shift(input int i);
    return !(i == 1 || i == 2 || i == 9 || i == 16);
  endfunction

  // Bit 1 is the MSB, so a left rotation moves bit 1 to the bottom.
  function automatic logic [1:28] rotl(input logic [1:28] v, input logic two);
    return two ? {v[3:28], v[1:2]} : {v[2:28], v[1]};
  endfunction

  function automatic logic [1:28] rotr(input logic [1:28] v, input logic two);
    return two ? {v[27:28], v[1:26]} : {v[28], v[1:27]};
  endfunction

  assign pc1_key = pc1(key_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      c     <= '0;
      d     <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            dir   <= decrypt;
            cnt   <= '0;
            state <= EMIT;
            if (decrypt) begin
              c <= pc1_key[1:28];
              d <= pc1_key[29:56];
            end else begin
              // The first encrypt subkey needs C1/D1, so round 1's shift happens here.
              c <= rotl(pc1_key[1:28], 1'b0);
              d <= rotl(pc1_key[29:56], 1'b0);
            end
          end
        end
        EMIT: begin
          if (sk_ready) begin
            if (cnt == LAST) begin
              state <= IDLE;
            end else begin
              cnt <= cnt + 4'd1;
              if (dir) begin
                // Undo round (16-cnt)'s shift to step from C(16-cnt) back to C(15-cnt).
                c <= rotr(c, two_shift(16 - int'(cnt)));
                d <= rotr(d, two_shift(16 - int'(cnt)));
              end else begin
                c <= rotl(c, two_shift(int'(cnt) + 2));
                d <= rotl(d, two_shift(int'(cnt) + 2));
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign key_ready = (state == IDLE);
  assign sk_valid  = (state == EMIT);
  assign sk_last   = (state == EMIT) && (cnt == LAST);
  assign sk_idx    = dir ? (LAST - cnt) : cnt;
  assign sk_out    = pc2({c, d});

endmodule
